scan_reg_bank: RTL and testbench



---
 rtl/scan_reg_bank.sv | 136 +++++++++++++
 tb/tb_scan_reg_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/scan_reg_bank.sv
// scan_reg_bank
//   Multi-bit scan register bank: asynchronous active-high reset to a
//   per-bit value, functional parallel load, and CHAINS independent scan
//   chains of length L = WIDTH/CHAINS that shift toward the LSB.
//
// Parameters
//   WIDTH      total register bits (>= 1)
//   CHAINS     number of scan chains (must divide WIDTH)
//   RESET_VAL  value loaded into Q while RST is high
//
// Ports
//   CLK         rising-edge clock
//   RST         asynchronous reset, active-high
//   D           functional parallel data
//   EN          functional load enable
//   SE          scan enable, overrides EN
//   SI          serial scan input, one bit per chain
//   Q           register state
//   QN          combinational inverse of Q
//   SO          serial scan output, one bit per chain (Q[c*L])
//   SHIFT_DONE  one-cycle registered pulse after L consecutive shift edges
//
// Build option
//   SCAN_REG_BANK_LOCKUP_EN  when defined, SO passes through a negedge
//                            lockup stage so it changes half a cycle after Q.
module scan_reg_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CHAINS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  D,
    input  logic              EN,
    input  logic              SE,
    input  logic [CHAINS-1:0] SI,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN,
    output logic [CHAINS-1:0] SO,
    output logic              SHIFT_DONE
);

    localparam int unsigned L     = WIDTH / CHAINS;
    localparam int unsigned CNT_W = $clog2(L + 1);

    generate
        if (WIDTH < 1 || CHAINS < 1 || (WIDTH % CHAINS) != 0) begin : g_bad_cfg
            $error("scan_reg_bank: WIDTH must be >= 1 and a multiple of CHAINS");
        end
    endgenerate

    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  shift_val;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [CHAINS-1:0] so_base;

    // Per-chain shift toward the LSB; SI[c] enters the chain's top bit.
    always_comb begin
        shift_val = q_q;
        for (int unsigned c = 0; c < CHAINS; c++) begin
            for (int unsigned i = 0; i + 1 < L; i++) begin
                shift_val[c*L + i] = q_q[c*L + i + 1];
            end
            shift_val[c*L + L - 1] = SI[c];
        end
    end

    // Ternary selection lets an X on SE/EN propagate into the affected bits.
    always_comb begin
        q_d    = SE ? shift_val : (EN ? D : q_q);
        cnt_d  = '0;
        done_d = 1'b0;
        if (SE) begin
            // Counter wraps instead of holding L; the wrap edge raises the pulse.
            if (cnt_q == CNT_W'(L - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        so_base = '0;
        for (int unsigned c = 0; c < CHAINS; c++) begin
            so_base[c] = q_q[c*L];
        end
    end

`ifdef SCAN_REG_BANK_LOCKUP_EN
    function automatic logic [CHAINS-1:0] so_reset_val();
        logic [CHAINS-1:0] v;
        v = '0;
        for (int unsigned c = 0; c < CHAINS; c++) begin
            v[c] = RESET_VAL[c*L];
        end
        return v;
    endfunction

    localparam logic [CHAINS-1:0] SO_RST = so_reset_val();

    logic [CHAINS-1:0] so_q;

    // Falling-edge capture gives half a cycle of hold margin to the next chain.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            so_q <= SO_RST;
        end else begin
            so_q <= so_base;
        end
    end

    assign SO = so_q;
`else
    assign SO = so_base;
`endif

    assign Q          = q_q;
    assign QN         = ~q_q;
    assign SHIFT_DONE = done_q;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed self-checking bench for scan_reg_bank (WIDTH=8, CHAINS=2,
// RESET_VAL=8'hA5, so L=4: chain 0 = bits 3..0, chain 1 = bits 7..4).
module tb_scan_reg_bank;

    logic       CLK;
    logic       RST;
    logic [7:0] D;
    logic       EN;
    logic       SE;
    logic [1:0] SI;
    logic [7:0] Q;
    logic [7:0] QN;
    logic [1:0] SO;
    logic       SHIFT_DONE;

    int checks = 0;
    int errors = 0;

    scan_reg_bank #(
        .WIDTH    (8),
        .CHAINS   (2),
        .RESET_VAL(8'hA5)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .D         (D),
        .EN        (EN),
        .SE        (SE),
        .SI        (SI),
        .Q         (Q),
        .QN        (QN),
        .SO        (SO),
        .SHIFT_DONE(SHIFT_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic to_neg();
        @(negedge CLK);
        #1;
    endtask

    logic [7:0] exp_q [8];
    logic       exp_sd[8];

    initial begin
        RST = 1'b0;
        D   = 8'h00;
        EN  = 1'b0;
        SE  = 1'b0;
        SI  = 2'b00;

        // Reset before any clock edge: SO = {RESET_VAL[4], RESET_VAL[0]} = 2'b01
        #1 RST = 1'b1;
        #1;
        check("rst_q",  Q,  8'hA5);
        check("rst_qn", QN, 8'h5A);
        check("rst_so", {6'b0, SO}, 8'h01);
        check("rst_sd", {7'b0, SHIFT_DONE}, 8'h00);
        tick();
        RST = 1'b0;

        // Functional load then hold
        EN = 1'b1; D = 8'h3C;
        tick();
        check("load_q",  Q,  8'h3C);
        check("load_qn", QN, 8'hC3);
        to_neg();
        check("load_so", {6'b0, SO}, 8'h02);
        EN = 1'b0; D = 8'hFF;
        tick();
        check("hold1_q", Q, 8'h3C);
        tick();
        check("hold2_q", Q, 8'h3C);

        // Asynchronous reset between edges
        to_neg();
        RST = 1'b1;
        #1;
        check("arst_q",  Q,  8'hA5);
        check("arst_qn", QN, 8'h5A);
        check("arst_so", {6'b0, SO}, 8'h01);
        check("arst_sd", {7'b0, SHIFT_DONE}, 8'h00);
        RST = 1'b0;

        // Clear to zero
        EN = 1'b1; D = 8'h00;
        tick();
        check("clr_q", Q, 8'h00);
        EN = 1'b0;

        // Scan shift: chain 0 gets 1s, chain 1 gets 0s, then swapped
        SE = 1'b1; SI = 2'b01;
        exp_q  = '{8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0};
        exp_sd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) SI = 2'b10;
            tick();
            check($sformatf("shift_q%0d", k),  Q, exp_q[k]);
            check($sformatf("shift_sd%0d", k), {7'b0, SHIFT_DONE}, {7'b0, exp_sd[k]});
            if (k == 3) begin
                to_neg();
                check("shift_so", {6'b0, SO}, 8'h01);
            end
        end

        // Counter clear: 3 shifts, 1 non-shift, 3 shifts -> no pulse; 4th -> pulse
        SI = 2'b00;
        exp_q  = '{8'h70, 8'h30, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_sd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            SE = (k == 3) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("cclr_q%0d", k),  Q, exp_q[k]);
            check($sformatf("cclr_sd%0d", k), {7'b0, SHIFT_DONE}, {7'b0, exp_sd[k]});
        end

        // SE overrides EN; reset after two shifts restarts the count
        SE = 1'b1; EN = 1'b1; D = 8'hFF; SI = 2'b11;
        tick();
        check("ovr_q0", Q, 8'h88);
        tick();
        check("ovr_q1", Q, 8'hCC);
        to_neg();
        RST = 1'b1;
        #1;
        check("mrst_q",  Q, 8'hA5);
        check("mrst_sd", {7'b0, SHIFT_DONE}, 8'h00);
        RST = 1'b0;
        exp_q  = '{8'hDA, 8'hED, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_sd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_q%0d", k),  Q, exp_q[k]);
            check($sformatf("post_sd%0d", k), {7'b0, SHIFT_DONE}, {7'b0, exp_sd[k]});
        end

        // SO timing relative to Q: Q[0] falls 1 -> 0 on this edge
        SE = 1'b0; EN = 1'b1; D = 8'h00;
        tick();
        check("lk_q", Q, 8'h00);
`ifdef SCAN_REG_BANK_LOCKUP_EN
        check("lk_so_rise", {6'b0, SO}, 8'h03);
`else
        check("lk_so_rise", {6'b0, SO}, 8'h00);
`endif
        to_neg();
        check("lk_so_fall", {6'b0, SO}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
